// File: rtl/icache_invalidation_engine.sv
`default_nettype none
// ============================================================================
// Module   : icache_invalidation_engine
// Brief    : Pops queued instruction-invalidation word addresses, looks the
//            line up in the icache tag bank through the shared tag port, and
//            clears the valid bit of every matching way. Never touches a set
//            while a line fill to that set is in flight.
//            Optional macro ICACHE_INV_LINE_FILTER_EN adds a one-entry filter
//            that completes repeat invalidations of the last line without a
//            tag access.
// Revision : 1.0 - initial release
// ============================================================================
module icache_invalidation_engine #(
    parameter  int WAYS   = 2,
    parameter  int LINES  = 256,
    parameter  int LINE_W = 8,
    localparam int IDX_W  = $clog2(LINES),
    localparam int OFF_W  = $clog2(LINE_W),
    localparam int TAG_W  = 30 - IDX_W - OFF_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [29:0]             inv_addr,
    input  logic                    inv_valid,
    output logic                    inv_completed,
    output logic                    tag_port_req,
    input  logic                    tag_port_gnt,
    output logic                    tag_read_en,
    output logic                    tag_write_en,
    output logic [IDX_W-1:0]        tag_index,
    output logic [WAYS-1:0]         tag_write_way,
    input  logic [WAYS-1:0]         tag_read_valid,
    input  logic [WAYS*TAG_W-1:0]   tag_read_tag,
    input  logic                    fill_active,
    input  logic [IDX_W-1:0]        fill_index
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_req_idx;
    logic [TAG_W-1:0]   r_req_tag;
    logic [WAYS-1:0]    r_hit_mask;

    logic [IDX_W-1:0]   w_in_idx;
    logic [TAG_W-1:0]   w_in_tag;
    logic               w_blocking;
    logic [WAYS-1:0]    w_hit;
    logic               w_filter_hit;
    logic               w_unused_offset;

    assign w_in_idx        = inv_addr[OFF_W +: IDX_W];
    assign w_in_tag        = inv_addr[29 -: TAG_W];
    // Word offset is irrelevant: the whole line is invalidated.
    assign w_unused_offset = ^inv_addr[OFF_W-1:0];

    // A set with a fill in flight must not be read or rewritten underneath it.
    assign w_blocking = fill_active && (fill_index == w_in_idx);

    // Per-way tag compare against the latched request; several ways may match.
    generate
        for (genvar w = 0; w < WAYS; w++) begin : g_hit
            assign w_hit[w] = tag_read_valid[w] &&
                              (tag_read_tag[w*TAG_W +: TAG_W] == r_req_tag);
        end
    endgenerate

`ifdef ICACHE_INV_LINE_FILTER_EN
    logic                     r_last_valid;
    logic [TAG_W+IDX_W-1:0]   r_last_line;

    assign w_filter_hit = inv_valid && r_last_valid && !w_blocking &&
                          ({w_in_tag, w_in_idx} == r_last_line);

    // Remember the last completed line; a fill to its set makes it stale.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_valid <= 1'b0;
            r_last_line  <= '0;
        end else if (fill_active && (fill_index == r_last_line[IDX_W-1:0])) begin
            r_last_valid <= 1'b0;
        end else if (inv_completed && (r_state != IDLE)) begin
            r_last_valid <= 1'b1;
            r_last_line  <= {r_req_tag, r_req_idx};
        end
    end
`else
    assign w_filter_hit = 1'b0;
`endif

    // Port handshake outputs: the arbiter grants in the same cycle as the
    // request, so strobes are decoded from state and live inputs. Reset
    // forces every output low so an interrupted operation never completes.
    always_comb begin
        inv_completed = 1'b0;
        tag_port_req  = 1'b0;
        tag_read_en   = 1'b0;
        tag_write_en  = 1'b0;
        tag_index     = '0;
        tag_write_way = '0;
        if (!rst) begin
            case (r_state)
                IDLE: begin
                    if (w_filter_hit) begin
                        inv_completed = 1'b1;
                    end else begin
                        tag_port_req = inv_valid && !w_blocking;
                        tag_read_en  = tag_port_req && tag_port_gnt;
                        if (tag_read_en) begin
                            tag_index = w_in_idx;
                        end
                    end
                end
                CHECK: begin
                    inv_completed = (w_hit == '0);
                end
                WRITE: begin
                    tag_port_req  = 1'b1;
                    tag_index     = r_req_idx;
                    tag_write_way = r_hit_mask;
                    if (tag_port_gnt) begin
                        tag_write_en  = 1'b1;
                        inv_completed = 1'b1;
                    end
                end
                default: begin
                    inv_completed = 1'b0;
                end
            endcase
        end
    end

    // Sequencer: read -> compare -> optional clearing write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_req_idx  <= '0;
            r_req_tag  <= '0;
            r_hit_mask <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (tag_read_en) begin
                        r_req_idx <= w_in_idx;
                        r_req_tag <= w_in_tag;
                        r_state   <= CHECK;
                    end
                end
                CHECK: begin
                    if (w_hit == '0) begin
                        r_state <= IDLE;
                    end else begin
                        r_hit_mask <= w_hit;
                        r_state    <= WRITE;
                    end
                end
                WRITE: begin
                    if (tag_port_gnt) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_icache_invalidation_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache_invalidation_engine
// Brief    : Directed bench for icache_invalidation_engine with a small
//            one-cycle-latency tag bank model feeding the read data.
// Revision : 1.0 - initial release
// ============================================================================
module tb_icache_invalidation_engine;

    localparam int WAYS  = 2;
    localparam int IDX_W = 8;
    localparam int TAG_W = 19;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [29:0]           inv_addr;
    logic                  inv_valid;
    logic                  inv_completed;
    logic                  tag_port_req;
    logic                  tag_port_gnt;
    logic                  tag_read_en;
    logic                  tag_write_en;
    logic [IDX_W-1:0]      tag_index;
    logic [WAYS-1:0]       tag_write_way;
    logic [WAYS-1:0]       tag_read_valid;
    logic [WAYS*TAG_W-1:0] tag_read_tag;
    logic                  fill_active;
    logic [IDX_W-1:0]      fill_index;

    logic [TAG_W-1:0] bank_tag [WAYS][256];
    logic             bank_val [WAYS][256];

    int n_total = 0;
    int n_bad   = 0;

    icache_invalidation_engine dut (
        .clk            (clk),
        .rst            (rst),
        .inv_addr       (inv_addr),
        .inv_valid      (inv_valid),
        .inv_completed  (inv_completed),
        .tag_port_req   (tag_port_req),
        .tag_port_gnt   (tag_port_gnt),
        .tag_read_en    (tag_read_en),
        .tag_write_en   (tag_write_en),
        .tag_index      (tag_index),
        .tag_write_way  (tag_write_way),
        .tag_read_valid (tag_read_valid),
        .tag_read_tag   (tag_read_tag),
        .fill_active    (fill_active),
        .fill_index     (fill_index)
    );

    always #5 clk = ~clk;

    // Tag bank read data appears one cycle after the read strobe.
    always @(posedge clk) begin
        if (tag_read_en) begin
            for (int w = 0; w < WAYS; w++) begin
                tag_read_valid[w]                <= bank_val[w][tag_index];
                tag_read_tag[w*TAG_W +: TAG_W]   <= bank_tag[w][tag_index];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after input changes.
    task automatic settle();
        #1;
    endtask

    function automatic logic [29:0] mk(input logic [TAG_W-1:0] t, input logic [IDX_W-1:0] i);
        return {t, i, 3'b000};
    endfunction

    // Queue pop after a completion cycle.
    task automatic pop();
        cyc();
        inv_valid = 1'b0;
        settle();
        check("idle_after_pop", {tag_port_req, inv_completed}, 2'b00);
    endtask

    initial begin
        rst = 1'b1; inv_addr = '0; inv_valid = 1'b0; tag_port_gnt = 1'b0;
        fill_active = 1'b0; fill_index = '0;
        tag_read_valid = '0; tag_read_tag = '0;
        for (int w = 0; w < WAYS; w++)
            for (int i = 0; i < 256; i++) begin
                bank_val[w][i] = 1'b0;
                bank_tag[w][i] = '0;
            end
        bank_tag[0][5] = 19'h111; bank_val[0][5] = 1'b1;
        bank_tag[1][5] = 19'h222; bank_val[1][5] = 1'b1;
        bank_tag[0][7] = 19'h055; bank_val[0][7] = 1'b1;
        bank_tag[1][7] = 19'h055; bank_val[1][7] = 1'b1;

        // ---------------- reset state ----------------
        cyc(); cyc();
        inv_valid = 1'b1; inv_addr = mk(19'h333, 8'd5); tag_port_gnt = 1'b1;
        settle();
        check("reset_outputs",
              {inv_completed, tag_port_req, tag_read_en, tag_write_en, tag_index, tag_write_way},
              '0);
        inv_valid = 1'b0;
        cyc();
        rst = 1'b0;
        settle();
        check("idle_no_valid", {tag_port_req, tag_read_en, inv_completed}, 3'b000);

        // ---------------- miss ----------------
        inv_valid = 1'b1; inv_addr = mk(19'h333, 8'd5);
        settle();
        check("miss_T_read", {tag_port_req, tag_read_en, tag_write_en}, 3'b110);
        check("miss_T_index", tag_index, 8'd5);
        check("miss_T_done", inv_completed, 1'b0);
        cyc();
        check("miss_T1_done", {inv_completed, tag_write_en, tag_read_en}, 3'b100);
        pop();

        // ---------------- hit way 1 ----------------
        inv_valid = 1'b1; inv_addr = mk(19'h222, 8'd5);
        settle();
        check("hit_T_read", {tag_read_en, tag_index}, {1'b1, 8'd5});
        cyc();
        check("hit_T1", {inv_completed, tag_write_en, tag_read_en}, 3'b000);
        cyc();
        check("hit_T2_write", {tag_write_en, inv_completed, tag_read_en}, 3'b110);
        check("hit_T2_way", tag_write_way, 2'b10);
        check("hit_T2_index", tag_index, 8'd5);
        pop();

        // ---------------- fill conflict ----------------
        fill_active = 1'b1; fill_index = 8'd5;
        inv_valid = 1'b1; inv_addr = mk(19'h333, 8'd5);
        for (int k = 0; k < 4; k++) begin
            settle();
            check("fill_block_req", {tag_port_req, tag_read_en, inv_completed}, 3'b000);
            cyc();
        end
        fill_active = 1'b0;
        settle();
        check("fill_release_read", {tag_read_en, tag_index}, {1'b1, 8'd5});
        cyc();
        check("fill_release_done", inv_completed, 1'b1);
        cyc();
        fill_active = 1'b1; fill_index = 8'd5;
        inv_addr = mk(19'h001, 8'd6);
        settle();
        check("fill_other_idx_read", {tag_port_req, tag_read_en, tag_index}, {2'b11, 8'd6});
        cyc();
        check("fill_other_idx_done", inv_completed, 1'b1);
        pop();
        fill_active = 1'b0;

        // ---------------- grant stall ----------------
        inv_valid = 1'b1; inv_addr = mk(19'h222, 8'd5);
        settle();
        check("stall_T_read", tag_read_en, 1'b1);
        cyc();
        tag_port_gnt = 1'b0;
        settle();
        check("stall_T1", {inv_completed, tag_write_en}, 2'b00);
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("stall_wait", {tag_port_req, tag_write_en, inv_completed}, 3'b100);
            check("stall_hold", {tag_index, tag_write_way}, {8'd5, 2'b10});
        end
        cyc();
        tag_port_gnt = 1'b1;
        settle();
        check("stall_T5_write", {tag_write_en, inv_completed, tag_write_way, tag_index},
              {2'b11, 2'b10, 8'd5});
        pop();

        // ---------------- reset in CHECK ----------------
        inv_valid = 1'b1; inv_addr = mk(19'h111, 8'd5);
        settle();
        check("rst_T_read", tag_read_en, 1'b1);
        cyc();
        rst = 1'b1;
        settle();
        check("rst_T1_quiet", {inv_completed, tag_write_en}, 2'b00);
        cyc();
        check("rst_outputs_zero",
              {inv_completed, tag_port_req, tag_read_en, tag_write_en, tag_index, tag_write_way},
              '0);
        cyc();
        rst = 1'b0;
        settle();
        check("rst_relookup", {tag_read_en, tag_index}, {1'b1, 8'd5});
        cyc();
        check("rst_relookup_T1", inv_completed, 1'b0);
        cyc();
        check("rst_relookup_write", {tag_write_en, inv_completed, tag_write_way}, {2'b11, 2'b01});
        pop();

        // ---------------- multi-way hit ----------------
        inv_valid = 1'b1; inv_addr = mk(19'h055, 8'd7);
        settle();
        check("multi_read", {tag_read_en, tag_index}, {1'b1, 8'd7});
        cyc();
        cyc();
        check("multi_write", {tag_write_en, inv_completed, tag_write_way, tag_index},
              {2'b11, 2'b11, 8'd7});
        pop();

        // ---------------- repeat of the last line ----------------
        inv_valid = 1'b1; inv_addr = mk(19'h055, 8'd7);
        settle();
`ifdef ICACHE_INV_LINE_FILTER_EN
        check("repeat_filtered", {inv_completed, tag_port_req, tag_read_en, tag_write_en}, 4'b1000);
`else
        check("repeat_lookup", {inv_completed, tag_read_en, tag_index}, {2'b01, 8'd7});
        cyc();
        cyc();
        check("repeat_write", {tag_write_en, inv_completed}, 2'b11);
`endif
        pop();

        // A fill to the set in between forces a full lookup.
        fill_active = 1'b1; fill_index = 8'd7;
        cyc();
        fill_active = 1'b0;
        inv_valid = 1'b1; inv_addr = mk(19'h055, 8'd7);
        settle();
        check("after_fill_lookup", {inv_completed, tag_read_en, tag_index}, {2'b01, 8'd7});
        cyc();
        cyc();
        check("after_fill_write", {tag_write_en, inv_completed, tag_write_way}, {2'b11, 2'b11});
        pop();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/icache_invalidation_engine.md
# icache_invalidation_engine

Consumer end of the queued instruction-invalidation interface: pops one queued word address at a time, looks the line up in the instruction-cache tag bank, clears the valid bit of every matching way and acknowledges with `inv_completed`. Sits between the invalidation queue and the icache tag-bank arbiter, which also serves line fills. It never invalidates a line while a fill to the same set is in flight.

## Interface
Parameters:
- `WAYS`, 2, associativity (1–8).
- `LINES`, 256, sets per way (power of two).
- `LINE_W`, 8, words per line (power of two).
- Derived: `IDX_W = $clog2(LINES)`, `OFF_W = $clog2(LINE_W)`, `TAG_W = 30 - IDX_W - OFF_W`.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `inv_addr`  in  30  queued word address; bits [OFF_W-1:0] are the word offset, then [IDX_W+OFF_W-1:OFF_W] the index, then the upper TAG_W bits the tag.
- `inv_valid`  in  1  queue head is valid.
- `inv_completed`  out  1  one-cycle pulse; pops the queue head.
- `tag_port_req`  out  1  request for the shared tag read/write port.
- `tag_port_gnt`  in  1  arbiter grant, same cycle as the request.
- `tag_read_en`  out  1  tag read strobe.
- `tag_write_en`  out  1  tag write strobe; the written entry is `{valid=0, tag=0}`.
- `tag_index`  out  IDX_W  set index for read or write.
- `tag_write_way`  out  WAYS  one-hot or multi-hot way mask for the write.
- `tag_read_valid`  in  WAYS  per-way valid bit, one cycle after `tag_read_en`.
- `tag_read_tag`  in  WAYS*TAG_W  per-way tags, one cycle after `tag_read_en`; way w occupies [w*TAG_W +: TAG_W].
- `fill_active`  in  1  line fill in progress.
- `fill_index`  in  IDX_W  set index of the active fill.

## Operation
- FSM states: IDLE, CHECK, WRITE.
- Blocking condition: `fill_active && fill_index == inv_addr` index field.
- IDLE:
  - `tag_port_req = inv_valid && !blocking`.
  - `tag_read_en = tag_port_req && tag_port_gnt`, with `tag_index` set to the request index.
  - On read issue: latch index and tag into `req_idx` and `req_tag`, then go to CHECK.
- CHECK:
  - Compute `hit[w] = tag_read_valid[w] && tag_read_tag[w] == req_tag`.
  - Miss (`hit == 0`): assert `inv_completed` and go to IDLE.
  - Hit: latch `hit` into `hit_mask` and go to WRITE.
- WRITE:
  - `tag_port_req = 1`.
  - On grant: `tag_write_en = 1`, `tag_index = req_idx`, `tag_write_way = hit_mask`, `inv_completed = 1`, then go to IDLE.
  - Without a grant, stay in WRITE and hold all latched values.
- `inv_addr` is sampled only in IDLE. The address must stay stable until `inv_completed`, which the queue guarantees because it only pops on `inv_completed`.
- Multiple matching ways (a corrupted or duplicated tag) are all cleared by the same write.
- Reset values:
  - State is IDLE.
  - All outputs are 0: `inv_completed`, `tag_port_req`, `tag_read_en`, `tag_write_en`, `tag_index`, `tag_write_way`.
  - `req_idx`, `req_tag` and `hit_mask` are 0.
- Reset mid-operation: return to IDLE with no completion pulse and no write. The entry is not popped.

## Timing
- Miss latency: read issued in cycle T, `inv_completed` in T+1.
- Hit latency: read in T, CHECK in T+1, write and `inv_completed` in T+2. Each cycle without a grant in WRITE adds one cycle.
- Throughput: at most one invalidation per 2 cycles (miss) or 3 cycles (hit). The next read can issue in the cycle after `inv_completed`.
- `tag_read_en` and `tag_write_en` are never both high in the same cycle, and neither is asserted without `tag_port_gnt`.
- A fill that starts while the FSM is in CHECK or WRITE does not abort the invalidation. The arbiter serializes fills after the write.

## Configuration
- `ICACHE_INV_LINE_FILTER_EN` defined:
  - Keep a valid-qualified `last_line = {req_tag, req_idx}` of the most recently completed invalidation.
  - In IDLE, if `inv_valid`, `last_line` is valid, the incoming line equals `last_line` and the request is not blocked: assert `inv_completed` in the same cycle with no port request and no tag access.
  - The filter entry is cleared by reset, and whenever `fill_active` is high with `fill_index == last_line` index.
- Undefined: no filter state exists, and every invalidation performs a tag read.

## Test plan
- Miss: way tags {0x111, 0x222} valid; `inv_addr` with tag 0x333, index 5, grant held at 1. Expect read at T with `tag_index = 5`, `inv_completed` at T+1, no write.
- Hit way 1: tag 0x222 at index 5. Expect read at T, write at T+2 with `tag_write_way = 2'b10` and `tag_index = 5`, and `inv_completed` at T+2.
- Grant stall: same hit as above with `tag_port_gnt = 0` for 3 cycles in WRITE. Expect the write and `inv_completed` at T+5, with `hit_mask` and `tag_index` stable throughout.
- Fill conflict: `fill_active = 1` with `fill_index = 5` for 4 cycles while `inv_valid` targets index 5. Expect no `tag_port_req` during those cycles, then the read issued in the cycle `fill_active` drops. A request to index 6 under the same fill proceeds immediately.
- Reset in CHECK: assert `rst` during T+1 of a hit. Expect no write and no `inv_completed`, all outputs 0 next cycle, and the same entry re-looked-up after reset releases.
- Filter (`ICACHE_INV_LINE_FILTER_EN`): two back-to-back invalidations to the same line. Expect the second to complete in one cycle with no tag access. Repeat with a fill to that index between them; the second must perform a full lookup.
